// File: rtl/mips_pkg.sv
// Shared MIPS definitions: ALU control codes and the multiply/divide sequencer states.
// The ALU decoder and muldiv_unit both import this package.
package mips_pkg;

    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_MFHI = 4'b1010;
    localparam logic [3:0] ALU_MFLO = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit with HI/LO registers.
// The unit takes 32 one-bit steps on operand magnitudes, then applies the signs in FIX.
module muldiv_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  alucontrol,
    input  logic        hien,
    input  logic        loen,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        divz
);

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? -v : v;
    endfunction

    md_state_e          state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, divz_q, divz_d;
    logic [63:0]        acc_q, acc_d;
    logic signed [31:0] srca_q, srca_d, srcb_q, srcb_d;
    logic               is_div_q, is_div_d;

    logic        accept;
    logic [31:0] mb;
    logic [32:0] add_sum, rem_sh, rem_diff;
    logic        neg_res;
    logic [63:0] prod;
    logic [31:0] quo, rem;

    assign accept = (state_q == S_IDLE) && start && hien && loen &&
                    ((alucontrol == ALU_MULT) || (alucontrol == ALU_DIV));

    // One radix-2 step: multiply adds into the upper half then shifts right;
    // divide shifts the partial remainder left and keeps the difference if no borrow.
    assign mb       = mag32(srcb_q);
    assign add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mb} : 33'd0);
    assign rem_sh   = acc_q[63:31];
    assign rem_diff = rem_sh - {1'b0, mb};

    assign neg_res = srca_q[31] ^ srcb_q[31];
    assign prod    = neg_res ? -acc_q : acc_q;
    assign quo     = neg_res ? -acc_q[31:0] : acc_q[31:0];
    assign rem     = srca_q[31] ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        divz_d   = divz_q;
        acc_d    = acc_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        is_div_d = is_div_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd0;
                    srca_d   = srca;
                    srcb_d   = srcb;
                    is_div_d = (alucontrol == ALU_DIV);
                    acc_d    = {32'd0, mag32(srca)};
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (rem_diff[32]) acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
                    else              acc_d = {rem_diff[31:0], acc_q[30:0], 1'b1};
                end else begin
                    acc_d = {add_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                end else if (srcb_q == 32'sd0) begin
                    hi_d   = srca_q;
                    lo_d   = 32'hFFFF_FFFF;
                    divz_d = 1'b1;
                end else begin
                    hi_d   = rem;
                    lo_d   = quo;
                    divz_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    // Operand and step registers are only meaningful between accept and FIX.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        srca_q   <= srca_d;
        srcb_q   <= srcb_d;
        is_div_q <= is_div_d;
    end

    always_comb begin
        result = 32'd0;
        if (alucontrol == ALU_MFHI)      result = hi_q;
        else if (alucontrol == ALU_MFLO) result = lo_q;
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign divz = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed MULT/DIV results, timing, stall and reset behaviour.
module tb_muldiv_unit;

    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alucontrol = 4'b0000;
    logic        hien = 1'b1;
    logic        loen = 1'b1;
    logic [31:0] srca = 32'd0;
    logic [31:0] srcb = 32'd0;
    logic [31:0] result;
    logic        busy, done, divz;

    int checks = 0;
    int failures = 0;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
        .hien(hien), .loen(loen), .srca(srca), .srcb(srcb),
        .result(result), .busy(busy), .done(done), .divz(divz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one accepting cycle; returns in cycle 1 after the accepting edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; alucontrol = op; srca = a; srcb = b;
        tick();
        start = 1'b0; alucontrol = 4'b0000;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        alucontrol = OP_MFHI; #1; hi = result;
        alucontrol = OP_MFLO; #1; lo = result;
        alucontrol = 4'b0000;
    endtask

    // Observe n cycles starting from the current one (cycle 1 = just after accept).
    task automatic watch(input int n, output int busy_n, output int done_first, output int done_n);
        busy_n = 0; done_first = 0; done_n = 0;
        for (int k = 1; k <= n; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_first == 0) done_first = k;
            end
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_divz);
        int bn, df, dn;
        logic [31:0] hi, lo;
        launch(op, a, b);
        watch(40, bn, df, dn);
        chk({tag, "_busy_cycles"}, 32'(bn), 32'd33);
        chk({tag, "_done_cycle"}, 32'(df), 32'd34);
        chk({tag, "_done_count"}, 32'(dn), 32'd1);
        read_hilo(hi, lo);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_divz"}, 32'(divz), 32'(exp_divz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bn, df, dn, k;
        logic [31:0] hi, lo;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_divz", 32'(divz), 32'd0);
        read_hilo(hi, lo);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        alucontrol = OP_MULT;
        #1;
        chk("result_other_op", result, 32'd0);
        alucontrol = 4'b0000;

        // 7 * -3 = -21
        run_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        // 5 / 0 -> divide-by-zero convention
        run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        // -0x2468ACF0 * -2^31 = 0x12345678 << 32; MULT keeps divz
        run_op("mult_big", OP_MULT, 32'hDB97_5310, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000, 1'b1);

        // Extra start and MFHI during busy: old HI visible, start not queued
        launch(OP_MULT, 32'd3, 32'd4);
        repeat (4) tick();
        start = 1'b1; alucontrol = OP_MULT; srca = 32'd100; srcb = 32'd100;
        repeat (2) tick();
        start = 1'b0; alucontrol = OP_MFHI;
        #1;
        chk("busy_read_hi", result, 32'h1234_5678);
        alucontrol = 4'b0000;
        watch(80, bn, df, dn);
        chk("busy_start_done_count", 32'(dn), 32'd1);
        read_hilo(hi, lo);
        chk("busy_start_hi", hi, 32'd0);
        chk("busy_start_lo", lo, 32'd12);

        // -7 / 2 = -3 rem -1; clears divz
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        // Most-negative / -1
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // Back-to-back: DIV 9/0, then accept MULT 6 * -7 in the done cycle
        launch(OP_DIV, 32'd9, 32'd0);
        k = 1;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("b2b_done_cycle", 32'(k), 32'd34);
        read_hilo(hi, lo);
        chk("b2b_div_hi", hi, 32'd9);
        chk("b2b_div_lo", lo, 32'hFFFF_FFFF);
        chk("b2b_div_divz", 32'(divz), 32'd1);
        launch(OP_MULT, 32'd6, 32'hFFFF_FFF9);
        chk("b2b_accepted_busy", 32'(busy), 32'd1);
        watch(40, bn, df, dn);
        chk("b2b_mult_done_cycle", 32'(df), 32'd34);
        read_hilo(hi, lo);
        chk("b2b_mult_hi", hi, 32'hFFFF_FFFF);
        chk("b2b_mult_lo", lo, 32'hFFFF_FFD6);
        chk("b2b_mult_divz", 32'(divz), 32'd1);

        // Asynchronous reset at RUN cycle 10
        launch(OP_MULT, 32'd3, 32'd5);
        repeat (9) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_divz", 32'(divz), 32'd0);
        read_hilo(hi, lo);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        watch(40, bn, df, dn);
        chk("post_reset_done_count", 32'(dn), 32'd0);
        chk("post_reset_busy_cycles", 32'(bn), 32'd0);
        read_hilo(hi, lo);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_lo", lo, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
